// File: rtl/regfile_param_sb.sv
// Parametrised register file: clocked write port, two combinational read ports,
// write-through bypass, optional hardwired zero register and per-register busy bits.
module regfile_param_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy1,
  output logic              busy2
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic              w_wr_ok;
  logic              w_cl_ok;
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_cidx;
  logic [ADDR_W-1:0] w_ra [2];
  logic [WIDTH-1:0]  w_rd [2];
  logic              w_bz [2];

  // An address names real, writable state: in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wr_ok = we && addr_ok(waddr);
  assign w_cl_ok = claim && addr_ok(claim_addr);
  assign w_widx  = waddr[IDX_W-1:0];
  assign w_cidx  = claim_addr[IDX_W-1:0];

  // The claim is applied after the write so it wins when both target one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[w_widx]  <= wdata;
        r_busy[w_widx] <= 1'b0;
      end
      if (w_cl_ok) r_busy[w_cidx] <= 1'b1;
    end
  end

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = '0;
      w_bz[p] = 1'b0;
      if (addr_ok(w_ra[p])) begin
        if ((BYPASS != 0) && w_wr_ok && (waddr == w_ra[p])) begin
          w_rd[p] = wdata;
          w_bz[p] = 1'b0;
        end else begin
          w_rd[p] = r_mem[w_ra[p][IDX_W-1:0]];
          w_bz[p] = r_busy[w_ra[p][IDX_W-1:0]];
        end
      end
    end
  end

  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign busy1 = w_bz[0];
  assign busy2 = w_bz[1];

endmodule

// File: tb/tb_regfile_param_sb.sv
// Directed bench for regfile_param_sb: a default instance (bypass, zero reg, 32 entries)
// and a second instance (no bypass, no zero reg, 20 entries) share the same stimulus.
module tb_regfile_param_sb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [15:0] wdata;
  logic        claim;
  logic [4:0]  claim_addr;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_busy1, a_busy2, b_busy1, b_busy2;

  typedef struct {
    int          cyc;
    int          id;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_tests;
  int   n_fail;

  regfile_param_sb #(.WIDTH(16), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .claim(claim), .claim_addr(claim_addr), .ra1(ra1), .ra2(ra2),
    .rd1(a_rd1), .rd2(a_rd2), .busy1(a_busy1), .busy2(a_busy2)
  );

  regfile_param_sb #(.WIDTH(16), .DEPTH(20), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .claim(claim), .claim_addr(claim_addr), .ra1(ra1), .ra2(ra2),
    .rd1(b_rd1), .rd2(b_rd2), .busy1(b_busy1), .busy2(b_busy2)
  );

  // Clock and cycle stamp
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int A_RD1 = 0, A_RD2 = 1, A_BZ1 = 2, A_BZ2 = 3;
  localparam int B_RD1 = 4, B_RD2 = 5, B_BZ1 = 6, B_BZ2 = 7;

  function automatic logic [15:0] actual(input int id);
    case (id)
      A_RD1:   return a_rd1;
      A_RD2:   return a_rd2;
      A_BZ1:   return {15'd0, a_busy1};
      A_BZ2:   return {15'd0, a_busy2};
      B_RD1:   return b_rd1;
      B_RD2:   return b_rd2;
      B_BZ1:   return {15'd0, b_busy1};
      default: return {15'd0, b_busy2};
    endcase
  endfunction

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [15:0] wd,
                       input logic c, input logic [4:0] ca, input logic [4:0] a1, input logic [4:0] a2);
    reset = r; we = w; waddr = wa; wdata = wd; claim = c; claim_addr = ca; ra1 = a1; ra2 = a2;
  endtask

  task automatic expect_val(input int id, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.id = id; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: samples on the falling edge, retiring entries stamped for this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = exp_q.pop_front();
      n_tests++;
      act = actual(e.id);
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s stale entry cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, act, e.val);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Reset edge with a competing write to r3
    drive(1, 1, 5'd3, 16'hFFFF, 0, 5'd0, 5'd3, 5'd3);
    tick();

    // C1: reset result; write r1 (bypass visible on A only)
    drive(0, 1, 5'd1, 16'h1232, 0, 5'd0, 5'd3, 5'd1);
    expect_val(A_RD1, 16'h0000, "rst_a_rd1");  expect_val(A_BZ1, 16'h0, "rst_a_bz1");
    expect_val(B_RD1, 16'h0000, "rst_b_rd1");  expect_val(B_BZ1, 16'h0, "rst_b_bz1");
    expect_val(A_RD2, 16'h1232, "byp_a_r1");   expect_val(B_RD2, 16'h0000, "nobyp_b_r1");
    tick();
    // C2: write r2
    drive(0, 1, 5'd2, 16'h1263, 0, 5'd0, 5'd1, 5'd4);
    expect_val(A_RD1, 16'h1232, "wr_a_r1");    expect_val(B_RD1, 16'h1232, "wr_b_r1");
    tick();
    // C3: read both
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd1, 5'd2);
    expect_val(A_RD1, 16'h1232, "rd_a_r1");    expect_val(A_RD2, 16'h1263, "rd_a_r2");
    expect_val(A_BZ1, 16'h0, "rd_a_bz1");      expect_val(A_BZ2, 16'h0, "rd_a_bz2");
    expect_val(B_RD1, 16'h1232, "rd_b_r1");    expect_val(B_RD2, 16'h1263, "rd_b_r2");
    tick();
    // C4: bypass on r5
    drive(0, 1, 5'd5, 16'hA06B, 0, 5'd0, 5'd5, 5'd5);
    expect_val(A_RD1, 16'hA06B, "byp_a_r5");   expect_val(A_BZ1, 16'h0, "byp_a_bz5");
    expect_val(A_RD2, 16'hA06B, "byp_a_r5p2"); expect_val(B_RD1, 16'h0000, "old_b_r5");
    tick();
    // C5
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd5, 5'd2);
    expect_val(A_RD1, 16'hA06B, "post_a_r5");  expect_val(B_RD1, 16'hA06B, "post_b_r5");
    tick();
    // C6: write and claim r0
    drive(0, 1, 5'd0, 16'hBEEF, 1, 5'd0, 5'd0, 5'd0);
    expect_val(A_RD1, 16'h0000, "z_a_nobyp");  expect_val(A_BZ1, 16'h0, "z_a_bz");
    expect_val(B_RD1, 16'h0000, "r0_b_old");
    tick();
    // C7: A keeps zero, B stored BEEF with busy set (claim wins)
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd0, 5'd0);
    expect_val(A_RD1, 16'h0000, "z_a_rd");     expect_val(A_BZ1, 16'h0, "z_a_bz_after");
    expect_val(B_RD1, 16'hBEEF, "r0_b_rd");    expect_val(B_BZ1, 16'h1, "r0_b_bz");
    tick();
    // C8
    expect_val(A_RD2, 16'h0000, "z_a_rd2");    expect_val(A_BZ2, 16'h0, "z_a_bz2");
    tick();
    // C9: claim r7, busy not yet visible
    drive(0, 0, 5'd0, 16'h0000, 1, 5'd7, 5'd7, 5'd7);
    expect_val(A_BZ1, 16'h0, "cl_a_pre");      expect_val(B_BZ1, 16'h0, "cl_b_pre");
    tick();
    // C10
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd7, 5'd7);
    expect_val(A_BZ1, 16'h1, "cl_a_bz");       expect_val(A_BZ2, 16'h1, "cl_a_bz2");
    expect_val(B_BZ1, 16'h1, "cl_b_bz");       expect_val(A_RD1, 16'h0000, "cl_a_rd");
    tick();
    // C11: write r7 clears busy (bypassed on A only)
    drive(0, 1, 5'd7, 16'h0042, 0, 5'd0, 5'd7, 5'd7);
    expect_val(A_RD1, 16'h0042, "w7_a_byp");   expect_val(A_BZ1, 16'h0, "w7_a_bz_byp");
    expect_val(B_BZ1, 16'h1, "w7_b_bz_pre");   expect_val(B_RD1, 16'h0000, "w7_b_rd_pre");
    tick();
    // C12
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd7, 5'd7);
    expect_val(A_RD1, 16'h0042, "w7_a_rd");    expect_val(A_BZ1, 16'h0, "w7_a_bz");
    expect_val(B_RD1, 16'h0042, "w7_b_rd");    expect_val(B_BZ1, 16'h0, "w7_b_bz");
    tick();
    // C13: simultaneous write and claim to r7
    drive(0, 1, 5'd7, 16'h0099, 1, 5'd7, 5'd7, 5'd7);
    expect_val(A_RD1, 16'h0099, "wc7_a_byp");  expect_val(A_BZ1, 16'h0, "wc7_a_bz_byp");
    expect_val(B_RD1, 16'h0042, "wc7_b_pre");  expect_val(B_BZ1, 16'h0, "wc7_b_bz_pre");
    tick();
    // C14
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd7, 5'd7);
    expect_val(A_RD1, 16'h0099, "wc7_a_rd");   expect_val(A_BZ1, 16'h1, "wc7_a_bz");
    expect_val(B_RD1, 16'h0099, "wc7_b_rd");   expect_val(B_BZ1, 16'h1, "wc7_b_bz");
    tick();
    // C15: address 25 is out of range for B only
    drive(0, 1, 5'd25, 16'h1111, 1, 5'd25, 5'd25, 5'd25);
    expect_val(A_RD1, 16'h1111, "a25_byp");    expect_val(B_RD1, 16'h0000, "oor_b_rd_pre");
    expect_val(B_BZ1, 16'h0, "oor_b_bz_pre");
    tick();
    // C16
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd25, 5'd5);
    expect_val(A_RD1, 16'h1111, "a25_rd");     expect_val(A_BZ1, 16'h1, "a25_bz");
    expect_val(B_RD1, 16'h0000, "oor_b_rd");   expect_val(B_BZ1, 16'h0, "oor_b_bz");
    expect_val(B_RD2, 16'hA06B, "oor_b_r5");
    tick();
    // C17: aliases of 25 in B untouched
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd9, 5'd2);
    expect_val(B_RD1, 16'h0000, "oor_b_r9");   expect_val(B_BZ1, 16'h0, "oor_b_bz9");
    expect_val(B_RD2, 16'h1263, "oor_b_r2");
    tick();
    // C18: reset mid-operation drops the write and claim on that edge
    drive(1, 1, 5'd2, 16'h5555, 1, 5'd3, 5'd2, 5'd7);
    tick();
    // C19
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd2, 5'd7);
    expect_val(A_RD1, 16'h0000, "mrst_a_r2");  expect_val(A_RD2, 16'h0000, "mrst_a_r7");
    expect_val(A_BZ2, 16'h0, "mrst_a_bz7");    expect_val(B_RD1, 16'h0000, "mrst_b_r2");
    expect_val(B_BZ2, 16'h0, "mrst_b_bz7");
    tick();
    // C20: top register of A, same register on both ports
    drive(0, 1, 5'd31, 16'hFFFF, 0, 5'd0, 5'd31, 5'd31);
    expect_val(A_RD1, 16'hFFFF, "r31_a_byp1"); expect_val(A_RD2, 16'hFFFF, "r31_a_byp2");
    expect_val(B_RD1, 16'h0000, "r31_b_oor");
    tick();
    // C21
    drive(0, 0, 5'd0, 16'h0000, 0, 5'd0, 5'd31, 5'd31);
    expect_val(A_RD1, 16'hFFFF, "r31_a_rd1");  expect_val(A_RD2, 16'hFFFF, "r31_a_rd2");
    expect_val(A_BZ1, 16'h0, "r31_a_bz");      expect_val(B_RD2, 16'h0000, "r31_b_rd");
    tick();
    tick();

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
